// File: rtl/key_event_scheduler.sv
// Button front end: 2-FF sync, per-key debounce, rising-edge events and a round-robin valid/ready event port.
// Optional build macro KEY_AUTOREPEAT_EN adds per-key auto-repeat while a key is held.
module key_event_scheduler #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_KEYS-1:0]         key_raw,
  output logic                      evt_valid,
  output logic [$clog2(N_KEYS)-1:0] evt_id,
  input  logic                      evt_ready,
  output logic [N_KEYS-1:0]         overrun,
  input  logic                      clr_ovr,
  output logic                      busy
);

  localparam int IDW = $clog2(N_KEYS);
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_e;

  logic [N_KEYS-1:0]         sync1_q, sync2_q;
  logic [N_KEYS-1:0]         deb_q, deb_d, deb_prev_q;
  logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_KEYS-1:0]         pending_q, pending_d;
  logic [N_KEYS-1:0]         overrun_q, overrun_d;
  logic [N_KEYS-1:0]         rise_s, event_s, xfer_mask_s, ovr_set_s;
  logic [2*N_KEYS-1:0]       pend2_s;
  logic [IDW:0]              off_s, sum_s;
  logic [IDW-1:0]            sel_idx_s, ptr_q, evt_id_q;
  logic                      sel_found_s, valid_next_s, xfer_s;
  logic                      evt_valid_q, busy_q;
  state_e                    state_q;

  // Synchronizer, debounced level, its previous value and the debounce counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= key_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // Debounce: the level only follows the synchronized input after DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign rise_s = deb_q & ~deb_prev_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [N_KEYS-1:0][RW-1:0] rep_q, rep_d;
  logic [N_KEYS-1:0]         rep_s;

  // Repeat counters restart on each press and fire every REPEAT_CYCLES while held.
  always_comb begin
    rep_d = '0;
    rep_s = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (rise_s[i]) begin
        rep_d[i] = '0;
      end else if (deb_q[i]) begin
        if (rep_q[i] == REP_MAX) begin
          rep_s[i] = 1'b1;
          rep_d[i] = '0;
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end else begin
        rep_d[i] = '0;
      end
    end
  end

  // Repeat counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign event_s = rise_s | rep_s;
`else
  assign event_s = rise_s;
`endif

  assign xfer_s      = evt_valid_q & evt_ready;
  assign xfer_mask_s = xfer_s ? ({{(N_KEYS-1){1'b0}}, 1'b1} << evt_id_q) : '0;
  // A key being transferred this cycle accepts a new edge as a fresh event, not an overrun.
  assign ovr_set_s   = event_s & pending_q & ~xfer_mask_s;

  // Pending and sticky overrun next state; a new overrun beats a clear in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~xfer_mask_s) | event_s;
    if (clr_ovr) begin
      overrun_d = ovr_set_s;
    end else begin
      overrun_d = overrun_q | ovr_set_s;
    end
  end

  // Pending and overrun registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Round-robin search: rotate pending by ptr and take the lowest set offset.
  always_comb begin
    pend2_s     = {pending_q, pending_q} >> ptr_q;
    sel_found_s = 1'b0;
    off_s       = '0;
    for (int j = N_KEYS - 1; j >= 0; j--) begin
      sel_found_s = sel_found_s | pend2_s[j];
      off_s       = pend2_s[j] ? (IDW+1)'(j) : off_s;
    end
    sum_s = {1'b0, ptr_q} + off_s;
    if (sum_s >= (IDW+1)'(N_KEYS)) begin
      sum_s = sum_s - (IDW+1)'(N_KEYS);
    end else begin
      sum_s = sum_s;
    end
    sel_idx_s = sum_s[IDW-1:0];
    if (state_q == OFFER) begin
      valid_next_s = ~evt_ready;
    end else begin
      valid_next_s = sel_found_s;
    end
  end

  // Offer FSM with registered valid/id/busy; IDLE always separates two offers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (|pending_d) | valid_next_s;
      case (state_q)
        IDLE: begin
          if (sel_found_s) begin
            evt_id_q    <= sel_idx_s;
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            ptr_q       <= (evt_id_q == IDW'(N_KEYS - 1)) ? '0 : evt_id_q + IDW'(1);
            evt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler (N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20).
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_raw = 4'b0000;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready = 1'b1;
  logic [3:0] overrun;
  logic       clr_ovr = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_ids[$];
  int xfer_cyc[$];
  int busy_cyc[$];
  int press_cyc;
  int lat;
  bit got_valid;

  key_event_scheduler #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .overrun(overrun),
    .clr_ovr(clr_ovr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer/busy monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (evt_valid && evt_ready) begin
        xfer_ids.push_back(int'(evt_id));
        xfer_cyc.push_back(cyc);
      end
      if (busy) busy_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    xfer_ids.delete();
    xfer_cyc.delete();
    busy_cyc.delete();
  endtask

  function automatic int id_at(input int k);
    return (xfer_ids.size() > k) ? xfer_ids[k] : -1;
  endfunction

  function automatic int cyc_at(input int k);
    return (xfer_cyc.size() > k) ? xfer_cyc[k] : -1000;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_id", 32'(evt_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    tick(2);

    // Single press of key 1
    clear_log();
    press_cyc = cyc;
    key_raw = 4'b0010;
    tick(10);
    key_raw = 4'b0000;
    tick(20);
    lat = cyc_at(0) - (press_cyc + 1);
    check_eq("single_count", 32'(xfer_ids.size()), 32'd1);
    check_eq("single_id", 32'(id_at(0)), 32'd1);
    check_eq("single_latency", 32'(lat), 32'd7);

    // Three-cycle glitch on key 0
    clear_log();
    key_raw = 4'b0001;
    tick(3);
    key_raw = 4'b0000;
    tick(15);
    check_eq("glitch_xfers", 32'(xfer_ids.size()), 32'd0);
    check_eq("glitch_busy", 32'(busy_cyc.size()), 32'd0);

    // Reset while offering
    evt_ready = 1'b0;
    key_raw = 4'b1000;
    got_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        got_valid = 1'b1;
        break;
      end
    end
    check_eq("midrst_offer", 32'(got_valid), 32'd1);
    check_eq("midrst_offer_id", 32'(evt_id), 32'd3);
    key_raw = 4'b0000;
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(evt_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    tick(2);
    reset = 1'b1;
    evt_ready = 1'b1;
    clear_log();
    @(negedge clk);
    check_eq("midrst_id", 32'(evt_id), 32'd0);
    tick(10);
    check_eq("midrst_dropped", 32'(xfer_ids.size()), 32'd0);

    // Round robin, keys 0,2,3 together from ptr 0
    clear_log();
    key_raw = 4'b1101;
    tick(10);
    key_raw = 4'b0000;
    tick(20);
    check_eq("rr_count", 32'(xfer_ids.size()), 32'd3);
    check_eq("rr_id0", 32'(id_at(0)), 32'd0);
    check_eq("rr_id1", 32'(id_at(1)), 32'd2);
    check_eq("rr_id2", 32'(id_at(2)), 32'd3);
    check_eq("rr_gap1", 32'(cyc_at(1) - cyc_at(0)), 32'd2);
    check_eq("rr_gap2", 32'(cyc_at(2) - cyc_at(1)), 32'd2);

    // Keys 0 and 3 after the pointer wrapped to 0
    clear_log();
    key_raw = 4'b1001;
    tick(10);
    key_raw = 4'b0000;
    tick(20);
    check_eq("rr2_count", 32'(xfer_ids.size()), 32'd2);
    check_eq("rr2_id0", 32'(id_at(0)), 32'd0);
    check_eq("rr2_id1", 32'(id_at(1)), 32'd3);

    // Backpressure: two presses of key 1 while the first is still offered
    clear_log();
    evt_ready = 1'b0;
    key_raw = 4'b0010;
    tick(10);
    key_raw = 4'b0000;
    tick(10);
    key_raw = 4'b0010;
    tick(10);
    key_raw = 4'b0000;
    tick(10);
    @(negedge clk);
    check_eq("bp_valid", 32'(evt_valid), 32'd1);
    check_eq("bp_id", 32'(evt_id), 32'd1);
    check_eq("bp_ovr", 32'(overrun), 32'd2);
    check_eq("bp_busy", 32'(busy), 32'd1);
    tick(1);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    @(negedge clk);
    check_eq("bp_ovr_clr", 32'(overrun), 32'd0);
    tick(1);
    evt_ready = 1'b1;
    tick(10);
    check_eq("bp_count", 32'(xfer_ids.size()), 32'd1);
    check_eq("bp_xfer_id", 32'(id_at(0)), 32'd1);
    @(negedge clk);
    check_eq("bp_idle_busy", 32'(busy), 32'd0);

    // Long hold of key 2
    clear_log();
    key_raw = 4'b0100;
    tick(50);
    key_raw = 4'b0000;
    tick(30);
    check_eq("hold_id", 32'(id_at(0)), 32'd2);
`ifdef KEY_AUTOREPEAT_EN
    check_eq("hold_count", 32'(xfer_ids.size()), 32'd3);
    check_eq("hold_rep1", 32'(cyc_at(1) - cyc_at(0)), 32'd20);
    check_eq("hold_rep2", 32'(cyc_at(2) - cyc_at(1)), 32'd20);
`else
    check_eq("hold_count", 32'(xfer_ids.size()), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
